// File: rtl/pbkdf2_pkg.sv
// PBKDF2 controller shared package.
// Holds FSM state encoding, bus widths and hmac message-mode encoding.
package pbkdf2_pkg;

    localparam int KEY_W  = 1024;
    localparam int MSG_W  = 512;
    localparam int SALT_W = 256;
    localparam int IDX_W  = 32;
    localparam int CNT_W  = 32;

    // hmac_mode encoding: first iteration hashes salt||INT(i) (36 bytes),
    // later iterations hash the previous 64-byte U value.
    localparam logic MODE_36B = 1'b0;
    localparam logic MODE_64B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ACC,
        ST_FIN
    } state_e;

    function automatic logic [MSG_W-1:0] first_msg(
        input logic [SALT_W-1:0] s,
        input logic [IDX_W-1:0]  i
    );
        return {s, i, {(MSG_W-SALT_W-IDX_W){1'b0}}};
    endfunction

endpackage

// File: rtl/pbkdf2_ctrl.sv
// PBKDF2 block controller: sequences c HMAC iterations on a shared hmac
// and XOR-accumulates U1..Uc into dk.
// Ports: clk, breset (async active-low), start/key/salt/blk_idx/iter_cnt
// request, busy/done/dk result, hmac_* towards the shared hmac engine.
// Optional macro PBKDF2_CTRL_ABORT_EN adds an abort input.
module pbkdf2_ctrl
    import pbkdf2_pkg::*;
(
    input  logic              clk,
    input  logic              breset,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [SALT_W-1:0] salt,
    input  logic [IDX_W-1:0]  blk_idx,
    input  logic [CNT_W-1:0]  iter_cnt,
    output logic              busy,
    output logic              done,
    output logic [MSG_W-1:0]  dk,
    output logic              hmac_rst_n,
    output logic              hmac_mode,
    output logic [KEY_W-1:0]  hmac_key,
    output logic [MSG_W-1:0]  hmac_msg,
    input  logic              hmac_done,
    input  logic [MSG_W-1:0]  hmac_out
`ifdef PBKDF2_CTRL_ABORT_EN
    ,
    input  logic              abort
`endif
);

    state_e           state_q, state_d;
    logic             ld_q, ld_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [MSG_W-1:0] acc_q, acc_d;
    logic [MSG_W-1:0] u_q, u_d;
    logic [MSG_W-1:0] dk_q, dk_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rstn_q, rstn_d;
    logic             mode_q, mode_d;
    logic             abort_w;

`ifdef PBKDF2_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        n_d     = n_q;
        c_d     = c_q;
        acc_d   = acc_q;
        u_d     = u_q;
        dk_d    = dk_q;
        msg_d   = msg_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rstn_d  = rstn_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort_w) begin
                    key_d   = key;
                    c_d     = (iter_cnt == '0) ? CNT_W'(1) : iter_cnt;
                    n_d     = CNT_W'(1);
                    acc_d   = '0;
                    msg_d   = first_msg(salt, blk_idx);
                    mode_d  = MODE_36B;
                    busy_d  = 1'b1;
                    ld_d    = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_q) begin
                    rstn_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    ld_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Capture the result before dropping hmac_rst_n, since
                // the engine may clear its output once held in reset.
                if (hmac_done) begin
                    u_d     = hmac_out;
                    rstn_d  = 1'b0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = acc_q ^ u_q;
                // n never exceeds c, so n+1 cannot wrap.
                if (n_q >= c_q) begin
                    state_d = ST_FIN;
                end else begin
                    n_d     = n_q + CNT_W'(1);
                    msg_d   = u_q;
                    mode_d  = MODE_64B;
                    ld_d    = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_FIN: begin
                dk_d    = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_w && (state_q == ST_LOAD ||
                        state_q == ST_RUN  ||
                        state_q == ST_ACC)) begin
            state_d = ST_IDLE;
            rstn_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            dk_d    = dk_q;
        end
    end

    always_ff @(posedge clk or negedge breset) begin
        if (!breset) begin
            state_q <= ST_IDLE;
            ld_q    <= 1'b0;
            n_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            u_q     <= '0;
            dk_q    <= '0;
            msg_q   <= '0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rstn_q  <= 1'b0;
            mode_q  <= MODE_36B;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            n_q     <= n_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            u_q     <= u_d;
            dk_q    <= dk_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rstn_q  <= rstn_d;
            mode_q  <= mode_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dk         = dk_q;
    assign hmac_rst_n = rstn_q;
    assign hmac_mode  = mode_q;
    assign hmac_key   = key_q;
    assign hmac_msg   = msg_q;

endmodule
